// File: rtl/fma16_vec_pkg.sv
// fma16_vec_pkg: record layout, FSM states and record packing for the
// FMA16 test-vector writer.
// Build option: FMA16_VEC_CHECK_EN adds the rexpected field to the record.
package fma16_vec_pkg;

`ifdef FMA16_VEC_CHECK_EN
    localparam int REC_W    = 92;
    localparam int REXP_LSB = 20;
    localparam int CTRL_LSB = 36;
`else
    localparam int REC_W    = 76;
    localparam int CTRL_LSB = 20;
`endif
    localparam int FLAGS_LSB = 0;
    localparam int RES_LSB   = 4;
    localparam int Z_LSB     = CTRL_LSB + 8;
    localparam int Y_LSB     = Z_LSB + 16;
    localparam int X_LSB     = Y_LSB + 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Field order matches the .tv files: x first (MSBs), flags last (LSBs).
    function automatic logic [REC_W-1:0] pack_rec(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z,
        input logic [7:0]  ctrl,
`ifdef FMA16_VEC_CHECK_EN
        input logic [15:0] rexp,
`endif
        input logic [15:0] result,
        input logic [3:0]  flags
    );
        logic [REC_W-1:0] rec;
        rec                   = '0;
        rec[X_LSB +: 16]      = x;
        rec[Y_LSB +: 16]      = y;
        rec[Z_LSB +: 16]      = z;
        rec[CTRL_LSB +: 8]    = ctrl;
`ifdef FMA16_VEC_CHECK_EN
        rec[REXP_LSB +: 16]   = rexp;
`endif
        rec[RES_LSB +: 16]    = result;
        rec[FLAGS_LSB +: 4]   = flags;
        return rec;
    endfunction

endpackage

// File: rtl/fma16_vec_fifo.sv
// fma16_vec_fifo: synchronous FIFO, WIDTH x DEPTH, one extra pointer bit
// to tell full from empty. Output is read from registers only.
module fma16_vec_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Flags from pointer compare; a full FIFO refuses pushes even if popping.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; stale contents are masked by the empty gate on rdata.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fma16_vector_writer.sv
// fma16_vector_writer: captures FMA16 operations as test-vector records,
// buffers them and streams them out over valid/ready.
// Build option: FMA16_VEC_CHECK_EN adds rexpected/err_count checking.
module fma16_vector_writer
    import fma16_vec_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic [15:0]      z,
    input  logic [7:0]       ctrl,
    input  logic [15:0]      result,
    input  logic [3:0]       flags,
`ifdef FMA16_VEC_CHECK_EN
    input  logic [15:0]      rexpected,
    output logic [31:0]      err_count,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_record,
    output logic [31:0]      rec_count,
    output logic             done
);
    state_e           state_q, state_d;
    logic             live_q, live_d;
    logic [31:0]      rec_count_q, rec_count_d;
    logic             accept, pop, full, empty;
    logic [REC_W-1:0] rec;
`ifdef FMA16_VEC_CHECK_EN
    logic [31:0]      err_count_q, err_count_d;
`endif

    // Handshakes and record packing; live_q holds in_ready low until the
    // first edge after reset release.
    always_comb begin
        in_ready  = live_q && (state_q == IDLE || state_q == RUN) && !full;
        accept    = in_valid && in_ready;
        out_valid = !empty;
        pop       = out_valid && out_ready;
        done      = (state_q == DONE);
        rec_count = rec_count_q;
`ifdef FMA16_VEC_CHECK_EN
        err_count = err_count_q;
        rec       = pack_rec(x, y, z, ctrl, rexpected, result, flags);
`else
        rec       = pack_rec(x, y, z, ctrl, result, flags);
`endif
    end

    fma16_vec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .wdata   (rec),
        .pop     (pop),
        .rdata   (out_record),
        .full    (full),
        .empty   (empty)
    );

    // Run-control FSM: capture until in_last, then drain, then park in DONE.
    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        case (state_q)
            IDLE:    if (accept) state_d = in_last ? DRAIN : RUN;
            RUN:     if (accept && in_last) state_d = DRAIN;
            DRAIN:   if (empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating counters for accepted records and checker mismatches.
    always_comb begin
        rec_count_d = rec_count_q;
        if (accept && rec_count_q != 32'hFFFF_FFFF) rec_count_d = rec_count_q + 32'd1;
`ifdef FMA16_VEC_CHECK_EN
        err_count_d = err_count_q;
        if (accept && result != rexpected && err_count_q != 32'hFFFF_FFFF)
            err_count_d = err_count_q + 32'd1;
`endif
    end

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            live_q      <= 1'b0;
            rec_count_q <= '0;
`ifdef FMA16_VEC_CHECK_EN
            err_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            live_q      <= live_d;
            rec_count_q <= rec_count_d;
`ifdef FMA16_VEC_CHECK_EN
            err_count_q <= err_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_fma16_vector_writer.sv
// tb_fma16_vector_writer: directed sequence with random record contents,
// checked against a queue-based reference of the writer's behaviour.
module tb_fma16_vector_writer;
`ifdef FMA16_VEC_CHECK_EN
    localparam int RW = 92;
`else
    localparam int RW = 76;
`endif
    localparam int DEPTH = 16;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0]   x = '0, y = '0, z = '0, result = '0;
    logic [7:0]    ctrl = '0;
    logic [3:0]    flags = '0;
    logic          in_ready, out_valid, done;
    logic [RW-1:0] out_record;
    logic [31:0]   rec_count;
`ifdef FMA16_VEC_CHECK_EN
    logic [15:0]   rexpected = '0;
    logic [31:0]   err_count;
`endif

    fma16_vector_writer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .x          (x),
        .y          (y),
        .z          (z),
        .ctrl       (ctrl),
        .result     (result),
        .flags      (flags),
`ifdef FMA16_VEC_CHECK_EN
        .rexpected  (rexpected),
        .err_count  (err_count),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_record (out_record),
        .rec_count  (rec_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference state: queued records, run phase (0 idle,1 run,2 drain,3 done).
    logic [RW-1:0] q[$];
    int            phase;
    bit            live;
    int unsigned   m_cnt, m_err;
    int            n_vec = 0, n_bad = 0, n_acc = 0;
    bit            stall_prev = 0;
    logic [RW-1:0] held_rec;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mkrec();
`ifdef FMA16_VEC_CHECK_EN
        return {x, y, z, ctrl, rexpected, result, flags};
`else
        return {x, y, z, ctrl, result, flags};
`endif
    endfunction

    task automatic rnd_in();
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
        ctrl = 8'($urandom); result = 16'($urandom); flags = 4'($urandom);
`ifdef FMA16_VEC_CHECK_EN
        rexpected = result;
`endif
    endtask

    // One clock: compare outputs, advance DUT, advance the reference.
    task automatic step();
        logic          exp_rdy, exp_ov, acc, pp, drain_empty;
        logic [RW-1:0] exp_rec;
        exp_rdy = live && (phase <= 1) && (q.size() < DEPTH);
        exp_ov  = (q.size() != 0);
        exp_rec = exp_ov ? q[0] : '0;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_ov);
        check("out_record", out_record, exp_rec);
        check("rec_count", rec_count, m_cnt);
        check("done", done, phase == 3);
`ifdef FMA16_VEC_CHECK_EN
        check("err_count", err_count, m_err);
`endif
        if (stall_prev) check("stall_hold", out_record, held_rec);
        stall_prev = exp_ov && !out_ready;
        held_rec   = out_record;
        acc = in_valid && exp_rdy;
        pp  = out_ready && exp_ov;
        drain_empty = (phase == 2) && (q.size() == 0);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            q.push_back(mkrec());
            n_acc++;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
`ifdef FMA16_VEC_CHECK_EN
            if (result != rexpected) m_err++;
`endif
            phase = in_last ? 2 : 1;
        end else if (drain_empty) begin
            phase = 3;
        end
        live = 1;
        @(negedge clk);
    endtask

    // Off-edge reset pulse of 3 ns; outputs must clear while it is low.
    task automatic pulse_reset();
        in_valid = 0;
        #1 reset_n = 0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rec_count", rec_count, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_record", out_record, '0);
        #1 reset_n = 1;
        q.delete();
        phase = 0; m_cnt = 0; m_err = 0; stall_prev = 0; n_acc = 0;
        @(negedge clk);
        live = 1;
    endtask

    initial begin
        phase = 0; live = 0; m_cnt = 0; m_err = 0;
        @(negedge clk);
        pulse_reset();

        // Single record with in_last.
        x = 16'h3C00; y = 16'h4000; z = 16'h0000; ctrl = 8'h08; result = 16'h4000; flags = 4'h0;
`ifdef FMA16_VEC_CHECK_EN
        rexpected = 16'h4000;
`endif
        in_valid = 1; in_last = 1; out_ready = 1;
        step();
        in_valid = 0; in_last = 0;
`ifndef FMA16_VEC_CHECK_EN
        check("single_record", out_record, 76'h3C00_4000_0000_08_4000_0);
`endif
        check("single_count", rec_count, 32'd1);
        step(); step();
        check("single_done", done, 1'b1);
        step();

        // Backpressure: fill to DEPTH, then release and finish 20 accepts.
        pulse_reset();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 20; i++) begin rnd_in(); step(); end
        check("fill_count", rec_count, 32'd16);
        check("fill_ready", in_ready, 1'b0);
        out_ready = 1;
        for (int i = 0; i < 100 && n_acc < 20; i++) begin rnd_in(); step(); end
        in_valid = 0;
        check("fill_total", rec_count, 32'd20);

        // Bring occupancy to 8, then push and pop together for 32 cycles.
        for (int i = 0; i < 40 && q.size() > 8; i++) step();
        in_valid = 1;
        for (int i = 0; i < 32; i++) begin rnd_in(); step(); end

        // Random stalls on both sides.
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom); rnd_in(); step();
        end

        // Close the run and wait for drain to finish.
        in_valid = 1; in_last = 1; rnd_in();
        for (int i = 0; i < 40 && phase < 2; i++) step();
        in_valid = 0; in_last = 0;
        for (int i = 0; i < 200 && phase < 3; i++) begin out_ready = 1'($urandom); step(); end
        step();
        check("run_done", done, 1'b1);

        // Reset mid-run with three records buffered, then restart.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; out_ready = (i == 2 || i == 3); rnd_in(); step();
        end
        in_valid = 0; out_ready = 0;
        pulse_reset();
        in_valid = 1; rnd_in(); step();
        in_valid = 0; out_ready = 1;
        step(); step();
        check("restart_count", rec_count, 32'd1);

`ifdef FMA16_VEC_CHECK_EN
        // Checker: two of four records mismatch.
        pulse_reset();
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rnd_in(); result = 16'h4000; rexpected = (i % 2 == 1) ? 16'h4001 : 16'h4000;
            step();
        end
        in_valid = 0;
        step(); step();
        check("err_count_final", err_count, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
